// File: rtl/vga_scroll_controller_pkg.sv
// Shared VGA defaults (640x480@60) and button bundle type for the scroll controller.
package vga_scroll_controller_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_t;

    localparam btn_t BTN_RELEASED = '1;
endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with raw sync, active and once-per-frame tick.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_active,
    output logic          o_frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == HW'(H_TOTAL - 1)) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == VW'(V_TOTAL - 1)) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt      = r_h_cnt;
    assign o_v_cnt      = r_v_cnt;
    assign o_active     = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    assign o_hs         = !((r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                            (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign o_vs         = !((r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                            (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign o_frame_tick = (r_h_cnt == '0) && (r_v_cnt == VW'(V_ACTIVE));
endmodule

// File: rtl/vga_scroll_controller.sv
// VGA front end: timing, wrap-around scrolled framebuffer addressing, and
// sync/blank/colour alignment to a fixed-latency memory path.
module vga_scroll_controller
    import vga_scroll_controller_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int ADDR_W   = 19,
    parameter int STEP_X   = 1,
    parameter int STEP_Y   = 1,
    parameter int MEM_LAT  = 2
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              up,
    input  logic              down,
    input  logic              left,
    input  logic              right,
    output logic [ADDR_W-1:0] oADDR,
    input  logic [23:0]       iBGR,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [7:0]        b_data,
    output logic [7:0]        g_data,
    output logic [7:0]        r_data
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_hs, w_vs, w_active, w_frame_tick;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .i_clk       (iVGA_CLK),
        .i_rst_n     (iRST_n),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_hs        (w_hs),
        .o_vs        (w_vs),
        .o_active    (w_active),
        .o_frame_tick(w_frame_tick)
    );

    btn_t r_btn_s1, r_btn_s2, w_press;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_btn_s1 <= BTN_RELEASED;
            r_btn_s2 <= BTN_RELEASED;
        end else begin
            r_btn_s1 <= {up, down, left, right};
            r_btn_s2 <= r_btn_s1;
        end
    end

    assign w_press = ~r_btn_s2;

    logic [HW-1:0] r_x_off, w_x_nxt, w_x_eff;
    logic [VW-1:0] r_y_off, w_y_nxt, w_y_eff;
    logic [HW:0]   w_x_inc, w_x_sum;
    logic [VW:0]   w_y_inc, w_y_sum;

    assign w_x_inc = {1'b0, r_x_off} + (HW+1)'(STEP_X);
    assign w_y_inc = {1'b0, r_y_off} + (VW+1)'(STEP_Y);

    // Opposing buttons cancel; each axis wraps within its active size.
    always_comb begin
        w_x_nxt = r_x_off;
        w_y_nxt = r_y_off;
        if (w_press.right && !w_press.left)
            w_x_nxt = (w_x_inc >= (HW+1)'(H_ACTIVE)) ? HW'(w_x_inc - (HW+1)'(H_ACTIVE))
                                                      : w_x_inc[HW-1:0];
        else if (w_press.left && !w_press.right)
            w_x_nxt = (r_x_off >= HW'(STEP_X)) ? r_x_off - HW'(STEP_X)
                                                : r_x_off + HW'(H_ACTIVE - STEP_X);
        if (w_press.down && !w_press.up)
            w_y_nxt = (w_y_inc >= (VW+1)'(V_ACTIVE)) ? VW'(w_y_inc - (VW+1)'(V_ACTIVE))
                                                      : w_y_inc[VW-1:0];
        else if (w_press.up && !w_press.down)
            w_y_nxt = (r_y_off >= VW'(STEP_Y)) ? r_y_off - VW'(STEP_Y)
                                                : r_y_off + VW'(V_ACTIVE - STEP_Y);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_x_off <= '0;
            r_y_off <= '0;
        end else if (w_frame_tick) begin
            r_x_off <= w_x_nxt;
            r_y_off <= w_y_nxt;
        end
    end

    assign w_x_sum = {1'b0, w_h_cnt} + {1'b0, r_x_off};
    assign w_y_sum = {1'b0, w_v_cnt} + {1'b0, r_y_off};
    assign w_x_eff = (w_x_sum >= (HW+1)'(H_ACTIVE)) ? HW'(w_x_sum - (HW+1)'(H_ACTIVE))
                                                     : w_x_sum[HW-1:0];
    assign w_y_eff = (w_y_sum >= (VW+1)'(V_ACTIVE)) ? VW'(w_y_sum - (VW+1)'(V_ACTIVE))
                                                     : w_y_sum[VW-1:0];

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)
            oADDR <= '0;
        else if (w_active)
            oADDR <= ADDR_W'(w_y_eff) * ADDR_W'(H_ACTIVE) + ADDR_W'(w_x_eff);
    end

    // Stage 0 lines up with oADDR; stage MEM_LAT lines up with iBGR.
    logic [MEM_LAT:0] r_hs_pipe, r_vs_pipe, r_act_pipe;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_hs_pipe  <= '1;
            r_vs_pipe  <= '1;
            r_act_pipe <= '0;
            oHS        <= 1'b1;
            oVS        <= 1'b1;
            oBLANK_n   <= 1'b0;
            b_data     <= '0;
            g_data     <= '0;
            r_data     <= '0;
        end else begin
            r_hs_pipe[0]  <= w_hs;
            r_vs_pipe[0]  <= w_vs;
            r_act_pipe[0] <= w_active;
            for (int i = 1; i <= MEM_LAT; i++) begin
                r_hs_pipe[i]  <= r_hs_pipe[i-1];
                r_vs_pipe[i]  <= r_vs_pipe[i-1];
                r_act_pipe[i] <= r_act_pipe[i-1];
            end
            oHS      <= r_hs_pipe[MEM_LAT];
            oVS      <= r_vs_pipe[MEM_LAT];
            oBLANK_n <= r_act_pipe[MEM_LAT];
            {b_data, g_data, r_data} <= r_act_pipe[MEM_LAT] ? iBGR : 24'd0;
        end
    end
endmodule

// File: tb/tb_vga_scroll_controller.sv
// Directed bench on a shrunken 16x8 raster (24x13 total) with a 2-clock ROM model.
module tb_vga_scroll_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
    logic [6:0]  addr;
    logic [23:0] bgr = '0, m1 = '0;
    logic        hs, vs, blank_n;
    logic [7:0]  b, g, r;
    int          cyc = 0, ntest = 0, nfail = 0, lows;

    always #5 clk = ~clk;

    vga_scroll_controller #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .ADDR_W(7), .STEP_X(1), .STEP_Y(1), .MEM_LAT(2)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .up(up), .down(down), .left(left), .right(right),
        .oADDR(addr), .iBGR(bgr),
        .oHS(hs), .oVS(vs), .oBLANK_n(blank_n),
        .b_data(b), .g_data(g), .r_data(r)
    );

    function automatic logic [23:0] pat(input logic [6:0] a);
        logic [7:0] x;
        x = {1'b0, a};
        return {x, ~x, x ^ 8'h5A};
    endfunction

    always @(posedge clk) begin
        m1  <= pat(addr);
        bgr <= m1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #12;
        check("rst_addr", 32'(addr), 0);
        check("rst_hs", 32'(hs), 1);
        check("rst_vs", 32'(vs), 1);
        check("rst_blank", 32'(blank_n), 0);
        check("rst_rgb", 32'({b, g, r}), 0);
        do_reset();

        goto(1);   check("addr_00", 32'(addr), 0);
        goto(3);   check("blank_pre", 32'(blank_n), 0);
        goto(4);   check("blank_first", 32'(blank_n), 1);
                   check("rgb_first", 32'({b, g, r}), 32'(pat(7'd0)));
        goto(21);  check("addr_hold", 32'(addr), 15);
                   check("hs_before", 32'(hs), 1);
        lows = 0;
        while (cyc < 45) begin
            tick();
            if (!hs) lows++;
            if (cyc == 22) check("hs_fall", 32'(hs), 0);
        end
        check("hs_width", 32'(lows), 3);
        tick();    check("hs_period", 32'(hs), 0);
        goto(54);  check("addr_5_2", 32'(addr), 37);
        goto(57);  check("blank_5_2", 32'(blank_n), 1);
                   check("rgb_5_2", 32'({b, g, r}), 32'(pat(7'd37)));
        goto(68);  check("blank_hblank", 32'(blank_n), 0);
                   check("rgb_hblank", 32'({b, g, r}), 0);
        goto(184); check("addr_last", 32'(addr), 127);
        goto(199);
        lows = 0;
        while (cyc < 320) begin
            tick();
            if (!vs) lows++;
            if (cyc == 219) check("vs_before", 32'(vs), 1);
            if (cyc == 220) check("vs_fall", 32'(vs), 0);
        end
        check("vs_width", 32'(lows), 48);

        right = 1'b0;
        goto(1140); right = 1'b1;
        goto(1249); check("right3_line", 32'(addr), 3);
        goto(1285); check("right3_x12", 32'(addr), 31);
        goto(1286); check("right3_wrap", 32'(addr), 16);

        goto(1290);
        rst_n = 1'b0;
        #1;
        check("midrst_addr", 32'(addr), 0);
        check("midrst_hs", 32'(hs), 1);
        check("midrst_vs", 32'(vs), 1);
        check("midrst_blank", 32'(blank_n), 0);
        check("midrst_rgb", 32'({b, g, r}), 0);
        do_reset();
        goto(30);  check("postrst_off0", 32'(addr), 21);

        up = 1'b0;
        goto(200); up = 1'b1;
        goto(313); check("up1_first", 32'(addr), 112);
        goto(337); check("up1_wrap", 32'(addr), 0);

        {up, down, left, right} = 4'b0000;
        goto(1450); {up, down, left, right} = 4'b1111;
        goto(1561); check("cancel_y", 32'(addr), 112);
        goto(1564); check("cancel_x", 32'(addr), 115);

        up = 1'b0; right = 1'b0;
        goto(1760); up = 1'b1; right = 1'b1;
        goto(1873); check("diag_first", 32'(addr), 97);
        goto(1912); check("diag_wrap", 32'(addr), 112);

        down = 1'b0;
        goto(2185); check("down_y7", 32'(addr), 113);
        goto(2390); down = 1'b1;
        goto(2497); check("down_wrap0", 32'(addr), 1);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
